// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding and sizing constants for the MEM-stage data memory.
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} memStateT;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_OFF_W = 2;
    localparam int MAX_WAIT_CYCLES = 15;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response bundle between pipeline and data memory.
interface dmem_responder_if;
    logic        DEnM;
    logic        MemWriteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        ErrM;
    modport master (output DEnM, MemWriteM, AddrM, WriteDataM, input ReadDataM, StallM, ErrM);
    modport slave  (input DEnM, MemWriteM, AddrM, WriteDataM, output ReadDataM, StallM, ErrM);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and a registered, resettable read port.
module dmem_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              ResetN,
    input  logic              writeEn,
    input  logic              readEn,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge CLK)
        if (writeEn) mem[idx] <= writeData;
    always_ff @(posedge CLK or negedge ResetN)
        if (!ResetN) readData <= '0;
        else if (readEn) readData <= mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory that stalls the MEM stage for WAIT_CYCLES+1 cycles per access.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 2
) (
    input logic             CLK,
    input logic             ResetN,
    dmem_responder_if.slave bus
);
    localparam int CNT_W = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_badWait
        $error("dmem_responder: WAIT_CYCLES out of range");
    end

    memStateT         state;
    logic [CNT_W-1:0] cnt;
    logic             aligned;
    logic             accessEn;

    assign aligned      = bus.DEnM & (bus.AddrM[BYTE_OFF_W-1:0] == '0);
    assign bus.ErrM     = bus.DEnM & ~aligned & (state == IDLE);
    assign bus.StallM   = bus.DEnM & ~bus.ErrM & (state == IDLE || state == BUSY);
    // A zero-wait build commits straight from IDLE; otherwise the last BUSY cycle commits.
    assign accessEn     = state == IDLE ? aligned & (WAIT_CYCLES == 0)
                                        : (state == BUSY) & bus.DEnM & (cnt == '0);

    always_ff @(posedge CLK or negedge ResetN)
        if (!ResetN) begin
            state <= IDLE;
            cnt   <= '0;
        end else
            case (state)
                IDLE:
                    if (aligned) begin
                        state <= WAIT_CYCLES == 0 ? DONE : BUSY;
                        cnt   <= CNT_LOAD;
                    end
                BUSY:
                    if (!bus.DEnM) state <= IDLE;
                    else if (cnt == '0) state <= DONE;
                    else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase

    dmem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .CLK      (CLK),
        .ResetN   (ResetN),
        .writeEn  (accessEn & bus.MemWriteM),
        .readEn   (accessEn & ~bus.MemWriteM),
        .idx      (bus.AddrM[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W]),
        .writeData(bus.WriteDataM),
        .readData (bus.ReadDataM)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a 2-wait and a 0-wait responder sharing one clock and reset.
module tb_dmem_responder;
    import mips_mem_pkg::*;

    logic CLK = 0;
    logic ResetN = 0;
    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nFails  = 0;

    // index 0 drives the zero-wait build, index 1 the two-wait build
    logic        den [2];
    logic        mw  [2];
    logic [31:0] addr[2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic        stall[2];
    logic        err [2];

    dmem_responder_if b0 ();
    dmem_responder_if b2 ();

    assign b0.DEnM = den[0];
    assign b0.MemWriteM = mw[0];
    assign b0.AddrM = addr[0];
    assign b0.WriteDataM = wd[0];
    assign rd[0] = b0.ReadDataM;
    assign stall[0] = b0.StallM;
    assign err[0] = b0.ErrM;
    assign b2.DEnM = den[1];
    assign b2.MemWriteM = mw[1];
    assign b2.AddrM = addr[1];
    assign b2.WriteDataM = wd[1];
    assign rd[1] = b2.ReadDataM;
    assign stall[1] = b2.StallM;
    assign err[1] = b2.ErrM;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u0 (.CLK(CLK), .ResetN(ResetN), .bus(b0));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u2 (.CLK(CLK), .ResetN(ResetN), .bus(b2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns stall cycles and DONE-cycle read data.
    task automatic access(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int st, output logic [31:0] r);
        den[s] = 1; mw[s] = we; addr[s] = a; wd[s] = d; st = 0;
        @(negedge CLK);
        while (stall[s] && st < 20) begin
            st++;
            @(negedge CLK);
        end
        r = rd[s];
        @(posedge CLK); #1;
        den[s] = 0;
    endtask

    int st;
    logic [31:0] r;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            den[i] = 0; mw[i] = 0; addr[i] = 0; wd[i] = 0;
        end
        repeat (3) @(posedge CLK);
        #1;
        check("rst_rd", rd[1], 32'h0);
        check("rst_stall", 32'(stall[1]), 32'h0);
        check("rst_err", 32'(err[1]), 32'h0);
        check("rst_state", 32'(u2.state), 32'(IDLE));
        check("rst_rd0", rd[0], 32'h0);
        ResetN = 1;
        @(posedge CLK); #1;

        access(1, 1, 32'h10, 32'hDEADBEEF, st, r);
        check("w2_store_stall", st, 3);
        check("w2_store_rd_held", r, 32'h0);
        access(1, 0, 32'h10, 32'h0, st, r);
        check("w2_load_stall", st, 3);
        check("w2_load_data", r, 32'hDEADBEEF);

        access(0, 1, 32'h04, 32'h12345678, st, r);
        check("w0_store_stall", st, 1);
        access(0, 1, 32'h08, 32'h0BADCAFE, st, r);
        check("w0_store2_stall", st, 1);
        access(0, 0, 32'h04, 32'h0, st, r);
        check("w0_load04_stall", st, 1);
        check("w0_load04_data", r, 32'h12345678);
        access(0, 0, 32'h08, 32'h0, st, r);
        check("w0_load08_stall", st, 1);
        check("w0_load08_data", r, 32'h0BADCAFE);

        den[1] = 1; mw[1] = 1; addr[1] = 32'h13; wd[1] = 32'h11111111;
        #1;
        check("mis_err", 32'(err[1]), 32'h1);
        check("mis_stall", 32'(stall[1]), 32'h0);
        @(posedge CLK); #1;
        check("mis_state", 32'(u2.state), 32'(IDLE));
        check("mis_rd_held", rd[1], 32'hDEADBEEF);
        den[1] = 0;
        #1;
        check("mis_err_clear", 32'(err[1]), 32'h0);
        @(posedge CLK); #1;
        access(1, 0, 32'h10, 32'h0, st, r);
        check("mis_mem_kept", r, 32'hDEADBEEF);

        access(1, 1, 32'h20, 32'h01234567, st, r);
        den[1] = 1; mw[1] = 1; addr[1] = 32'h20; wd[1] = 32'hAAAA5555;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("abort_in_busy", 32'(u2.state), 32'(BUSY));
        den[1] = 0;
        @(posedge CLK); #1;
        check("abort_state", 32'(u2.state), 32'(IDLE));
        check("abort_rd_held", rd[1], 32'hDEADBEEF);
        access(1, 0, 32'h20, 32'h0, st, r);
        check("abort_mem_old", r, 32'h01234567);

        den[1] = 1; mw[1] = 1; addr[1] = 32'h20; wd[1] = 32'hAAAA5555;
        @(posedge CLK); #1;
        ResetN = 0;
        #1;
        check("rstmid_state", 32'(u2.state), 32'(IDLE));
        check("rstmid_rd", rd[1], 32'h0);
        den[1] = 0;
        @(posedge CLK); #1;
        ResetN = 1;
        @(posedge CLK); #1;
        access(1, 0, 32'h20, 32'h0, st, r);
        check("rstmid_mem_old", r, 32'h01234567);
        check("rstmid_stall", st, 3);

        access(1, 1, 32'h100, 32'hCAFEF00D, st, r);
        access(1, 0, 32'h000, 32'h0, st, r);
        check("wrap_data", r, 32'hCAFEF00D);
        access(1, 0, 32'h10, 32'h0, st, r);
        check("wrap_other_word", r, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
